// File: rtl/sum_sampler_pkg.sv
// Shared defaults and types for the sum change sampler.
package sum_sampler_pkg;

  localparam int unsigned DATA_W_DEF = 10;
  localparam int unsigned DEPTH_DEF  = 4;

  typedef logic [DATA_W_DEF-1:0] sum_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with explicit occupancy counter; a push into a full FIFO is
// accepted only when a pop frees a slot in the same cycle.
module sync_fifo
  import sum_sampler_pkg::*;
#(
  parameter int unsigned DataW = DATA_W_DEF,
  parameter int unsigned Depth = DEPTH_DEF,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [DataW-1:0] wdata_i,
  output logic             push_ok_o,
  output logic [DataW-1:0] rdata_o,
  output logic [CntW-1:0]  count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [DataW-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             pop_ok;
  logic             push_ok;

  assign full_o    = (count_q == CntW'(Depth));
  assign empty_o   = (count_q == '0);
  assign pop_ok    = pop_i && !empty_o;
  assign push_ok   = push_i && (!full_o || pop_ok);
  assign push_ok_o = push_ok;
  assign rdata_o   = mem_q[rd_ptr_q];
  assign count_o   = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/sum_change_sampler.sv
// Pushes the adder sum into a FIFO only when it changes; tracks dropped pushes
// with a sticky overflow flag and a saturating drop counter.
module sum_change_sampler
  import sum_sampler_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned DROP_W = 8,
  localparam int unsigned CntW  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_en,
  input  logic [DATA_W-1:0] c_in,
  input  logic              clear_ovf,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CntW-1:0]   count,
  output logic              full,
  output logic              empty,
  output logic              overflow,
  output logic [DROP_W-1:0] drop_cnt
);

  logic [DATA_W-1:0] last_val_q, last_val_d;
  logic              last_vld_q, last_vld_d;
  logic              overflow_q, overflow_d;
  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;
  logic              push_req;
  logic              push_ok;
  logic              pop;
  logic              drop;

  assign push_req  = sample_en && (!last_vld_q || (c_in != last_val_q));
  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;
  assign drop      = push_req && !push_ok;

  sync_fifo #(
    .DataW (DATA_W),
    .Depth (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_i    (push_req),
    .pop_i     (pop),
    .wdata_i   (c_in),
    .push_ok_o (push_ok),
    .rdata_o   (out_data),
    .count_o   (count),
    .full_o    (full),
    .empty_o   (empty)
  );

  always_comb begin
    last_val_d = last_val_q;
    last_vld_d = last_vld_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    // A requested value becomes the new reference even if it was dropped.
    if (push_req) begin
      last_val_d = c_in;
      last_vld_d = 1'b1;
    end
    if (clear_ovf) begin
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end
    // Drop takes priority over a simultaneous clear.
    if (drop) begin
      overflow_d = 1'b1;
      if (clear_ovf) begin
        drop_cnt_d = DROP_W'(1);
      end else if (drop_cnt_q != {DROP_W{1'b1}}) begin
        drop_cnt_d = drop_cnt_q + DROP_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_val_q <= '0;
      last_vld_q <= 1'b0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      last_val_q <= last_val_d;
      last_vld_q <= last_vld_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign overflow = overflow_q;
  assign drop_cnt = drop_cnt_q;

endmodule
